// File: rtl/ship_supervisor.sv
// rtl/ship_supervisor.sv - ship mode supervisor: threat/stealth/emergency FSM with paced power and O2 refills
module ship_supervisor #(
    parameter int n         = 32,
    parameter int PWR_LOW   = 20,
    parameter int O2_LOW    = 20,
    parameter int REFILL    = 500,
    parameter int TEMP_WARN = 90,
    parameter int HOLD      = 8,
    parameter int COOLDOWN  = 4,
    parameter int ABORT_CYC = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         threat,
    input  logic         req_stealth,
    input  logic [n-1:0] outpower,
    input  logic [n-1:0] outo2,
    input  logic [n-1:0] outtemp,
    input  logic         fatal,
    output logic [3:0]   mode,
    output logic         chrg,
    output logic         o2sup,
    output logic [n-1:0] pwr,
    output logic [n-1:0] o2,
    output logic         atk,
    output logic         abort,
    output logic [2:0]   state
);

    typedef enum logic [2:0] {
        CRUISE  = 3'd0,
        DEFEND  = 3'd1,
        STEALTH = 3'd2,
        EMERG   = 3'd3,
        ABORT   = 3'd4
    } state_t;

    state_t       cur, nxt;
    logic [n-1:0] hold_cnt, hold_nxt;
    logic [n-1:0] fatal_cnt, fatal_nxt;
    logic [n-1:0] pwr_cd, o2_cd;
    logic         pwr_fire, o2_fire;
    logic         stealth_ok;

    assign state = cur;
    assign stealth_ok = req_stealth && (outpower > n'(PWR_LOW)) && (outtemp < n'(TEMP_WARN));

    function automatic logic [3:0] mode_of(input state_t s);
        case (s)
            CRUISE:  mode_of = 4'b0001;
            DEFEND:  mode_of = 4'b0100;
            STEALTH: mode_of = 4'b1000;
            EMERG:   mode_of = 4'b0010;
            default: mode_of = 4'b0000;
        endcase
    endfunction

    always_comb begin
        nxt       = cur;
        hold_nxt  = hold_cnt;
        fatal_nxt = '0;
        case (cur)
            CRUISE: begin
                if (fatal) begin
                    nxt       = EMERG;
                    fatal_nxt = n'(1);
                end else if (threat) begin
                    nxt      = DEFEND;
                    hold_nxt = n'(HOLD);
                end else if (stealth_ok) begin
                    nxt = STEALTH;
                end
            end
            DEFEND: begin
                if (fatal) begin
                    nxt       = EMERG;
                    fatal_nxt = n'(1);
                    hold_nxt  = '0;
                end else if (threat) begin
                    hold_nxt = n'(HOLD);
                end else if (hold_cnt <= n'(1)) begin
                    // leave on the edge where the hold count reaches zero
                    nxt      = CRUISE;
                    hold_nxt = '0;
                end else begin
                    hold_nxt = hold_cnt - n'(1);
                end
            end
            STEALTH: begin
                if (fatal) begin
                    nxt       = EMERG;
                    fatal_nxt = n'(1);
                end else if (threat) begin
                    nxt      = DEFEND;
                    hold_nxt = n'(HOLD);
                end else if (!stealth_ok) begin
                    nxt = CRUISE;
                end
            end
            EMERG: begin
                if (fatal) begin
                    if (fatal_cnt >= n'(ABORT_CYC - 1)) begin
                        nxt       = ABORT;
                        fatal_nxt = n'(ABORT_CYC);
                    end else begin
                        fatal_nxt = fatal_cnt + n'(1);
                    end
                end else begin
                    nxt = CRUISE;
                end
            end
            default: begin
                nxt       = ABORT;
                fatal_nxt = fatal_cnt;
            end
        endcase
    end

    // refills key off the state being entered, so an emergency entry refills at once
    assign pwr_fire = (nxt != ABORT) && (pwr_cd == '0) && ((outpower < n'(PWR_LOW)) || (nxt == EMERG));
    assign o2_fire  = (nxt != ABORT) && (o2_cd == '0) && ((outo2 < n'(O2_LOW)) || (nxt == EMERG));

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= CRUISE;
            hold_cnt  <= '0;
            fatal_cnt <= '0;
            pwr_cd    <= '0;
            o2_cd     <= '0;
            mode      <= 4'b0001;
            chrg      <= 1'b0;
            o2sup     <= 1'b0;
            pwr       <= '0;
            o2        <= '0;
            atk       <= 1'b0;
            abort     <= 1'b0;
        end else begin
            cur       <= nxt;
            hold_cnt  <= hold_nxt;
            fatal_cnt <= fatal_nxt;
            pwr_cd    <= pwr_fire ? n'(COOLDOWN) : ((pwr_cd != '0) ? pwr_cd - n'(1) : '0);
            o2_cd     <= o2_fire ? n'(COOLDOWN) : ((o2_cd != '0) ? o2_cd - n'(1) : '0);
            mode      <= mode_of(nxt);
            chrg      <= pwr_fire;
            o2sup     <= o2_fire;
            pwr       <= pwr_fire ? n'(REFILL) : '0;
            o2        <= o2_fire ? n'(REFILL) : '0;
            atk       <= threat && (nxt != ABORT);
            abort     <= (nxt == ABORT);
        end
    end

endmodule

// File: tb/tb_ship_supervisor.sv
// tb/tb_ship_supervisor.sv - directed self-checking bench for ship_supervisor
module tb_ship_supervisor;

    logic        clk = 1'b0;
    logic        rst, threat, req_stealth, fatal;
    logic [31:0] outpower, outo2, outtemp;
    logic [3:0]  mode;
    logic        chrg, o2sup, atk, abort;
    logic [31:0] pwr, o2;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    ship_supervisor dut (
        .clk(clk), .rst(rst), .threat(threat), .req_stealth(req_stealth),
        .outpower(outpower), .outo2(outo2), .outtemp(outtemp), .fatal(fatal),
        .mode(mode), .chrg(chrg), .o2sup(o2sup), .pwr(pwr), .o2(o2),
        .atk(atk), .abort(abort), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        threat = 0; req_stealth = 0; fatal = 0;
        outpower = 100; outo2 = 100; outtemp = 50;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); outpower = 5; threat = 1;
        rst = 1; step();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (mode !== 4'b0001) begin n_fail++; $display("FAIL reset_mode got %b want 0001", mode); end
        n_checks++; if ({chrg, o2sup, atk, abort} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {chrg, o2sup, atk, abort}); end
        n_checks++; if ((pwr !== 32'd0) || (o2 !== 32'd0)) begin n_fail++; $display("FAIL reset_values got pwr=%0d o2=%0d want 0 0", pwr, o2); end
        rst = 0; idle_inputs();
    endtask

    task automatic test_power_refill();
        do_reset();
        outpower = 10;
        step();
        n_checks++; if ({chrg, o2sup} !== 2'b10) begin n_fail++; $display("FAIL pwr_first got chrg/o2sup=%b want 10", {chrg, o2sup}); end
        n_checks++; if (pwr !== 32'd500) begin n_fail++; $display("FAIL pwr_value got %0d want 500", pwr); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if ((chrg !== 1'b0) || (pwr !== 32'd0)) begin n_fail++; $display("FAIL pwr_cooldown_%0d got chrg=%b pwr=%0d want 0 0", i, chrg, pwr); end
        end
        step();
        n_checks++; if (chrg !== 1'b1) begin n_fail++; $display("FAIL pwr_second got %b want 1", chrg); end
        outpower = 20;
        repeat (5) step();
        n_checks++; if (chrg !== 1'b0) begin n_fail++; $display("FAIL pwr_at_threshold got %b want 0", chrg); end
    endtask

    task automatic test_o2_both();
        do_reset();
        outpower = 10; outo2 = 19;
        step();
        n_checks++; if ({chrg, o2sup} !== 2'b11) begin n_fail++; $display("FAIL both_strobes got %b want 11", {chrg, o2sup}); end
        n_checks++; if (o2 !== 32'd500) begin n_fail++; $display("FAIL o2_value got %0d want 500", o2); end
        outpower = 100;
        step();
        n_checks++; if (o2sup !== 1'b0) begin n_fail++; $display("FAIL o2_one_cycle got %b want 0", o2sup); end
    endtask

    task automatic test_threat_hold();
        do_reset();
        threat = 1; step(); threat = 0;
        n_checks++; if ((mode !== 4'b0100) || (state !== 3'd1)) begin n_fail++; $display("FAIL threat_enter got mode=%b state=%0d want 0100 1", mode, state); end
        n_checks++; if (atk !== 1'b1) begin n_fail++; $display("FAIL threat_atk got %b want 1", atk); end
        for (int i = 1; i <= 7; i++) begin
            step();
            n_checks++; if (mode !== 4'b0100) begin n_fail++; $display("FAIL hold_cycle_%0d got %b want 0100", i, mode); end
        end
        n_checks++; if (atk !== 1'b0) begin n_fail++; $display("FAIL atk_follow got %b want 0", atk); end
        step();
        n_checks++; if (mode !== 4'b0001) begin n_fail++; $display("FAIL hold_exit got %b want 0001", mode); end
    endtask

    task automatic test_stealth_temp();
        do_reset();
        req_stealth = 1; outpower = 20;
        step();
        n_checks++; if (mode !== 4'b0001) begin n_fail++; $display("FAIL stealth_low_power got %b want 0001", mode); end
        outpower = 21; outtemp = 88;
        step();
        n_checks++; if ((mode !== 4'b1000) || (state !== 3'd2)) begin n_fail++; $display("FAIL stealth_88 got mode=%b state=%0d want 1000 2", mode, state); end
        outtemp = 89; step();
        n_checks++; if (mode !== 4'b1000) begin n_fail++; $display("FAIL stealth_89 got %b want 1000", mode); end
        outtemp = 90; step();
        n_checks++; if (mode !== 4'b0001) begin n_fail++; $display("FAIL stealth_90 got %b want 0001", mode); end
    endtask

    task automatic test_fatal_abort();
        do_reset();
        fatal = 1;
        step();
        n_checks++; if ((mode !== 4'b0010) || (state !== 3'd3)) begin n_fail++; $display("FAIL emerg_enter got mode=%b state=%0d want 0010 3", mode, state); end
        n_checks++; if ({chrg, o2sup} !== 2'b11) begin n_fail++; $display("FAIL emerg_refill got %b want 11", {chrg, o2sup}); end
        for (int i = 2; i <= 15; i++) begin
            step();
            n_checks++; if ((state !== 3'd3) || (abort !== 1'b0)) begin n_fail++; $display("FAIL emerg_cycle_%0d got state=%0d abort=%b want 3 0", i, state, abort); end
        end
        threat = 1; outpower = 1; outo2 = 1;
        step();
        n_checks++; if ((state !== 3'd4) || (abort !== 1'b1) || (mode !== 4'b0000)) begin n_fail++; $display("FAIL abort_enter got state=%0d abort=%b mode=%b want 4 1 0000", state, abort, mode); end
        fatal = 0;
        repeat (6) begin
            step();
            n_checks++; if ({chrg, o2sup, atk} !== 3'b000) begin n_fail++; $display("FAIL abort_quiet got chrg/o2sup/atk=%b want 000", {chrg, o2sup, atk}); end
        end
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL abort_terminal got %0d want 4", state); end
        rst = 1; step(); rst = 0;
        n_checks++; if ((state !== 3'd0) || (abort !== 1'b0) || (mode !== 4'b0001)) begin n_fail++; $display("FAIL abort_reset got state=%0d abort=%b mode=%b want 0 0 0001", state, abort, mode); end
        idle_inputs();
    endtask

    task automatic test_fatal_recover();
        do_reset();
        fatal = 1;
        repeat (10) step();
        fatal = 0;
        step();
        n_checks++; if ((state !== 3'd0) || (abort !== 1'b0)) begin n_fail++; $display("FAIL fatal_recover got state=%0d abort=%b want 0 0", state, abort); end
        fatal = 1;
        repeat (10) step();
        n_checks++; if ((state !== 3'd3) || (abort !== 1'b0)) begin n_fail++; $display("FAIL fatal_counter_cleared got state=%0d abort=%b want 3 0", state, abort); end
        fatal = 0; step();
    endtask

    task automatic test_fatal_threat_stealth();
        do_reset();
        req_stealth = 1; step();
        fatal = 1; threat = 1; step();
        n_checks++; if ((state !== 3'd3) || (mode !== 4'b0010)) begin n_fail++; $display("FAIL fatal_beats_threat got state=%0d mode=%b want 3 0010", state, mode); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_ops();
        do_reset();
        threat = 1; step(); threat = 0; step();
        rst = 1; step(); rst = 0;
        step();
        n_checks++; if ((state !== 3'd0) || (mode !== 4'b0001)) begin n_fail++; $display("FAIL reset_mid_hold got state=%0d mode=%b want 0 0001", state, mode); end
        outpower = 10; step();
        rst = 1; step();
        n_checks++; if (chrg !== 1'b0) begin n_fail++; $display("FAIL reset_mid_refill got %b want 0", chrg); end
        rst = 0; step();
        n_checks++; if (chrg !== 1'b1) begin n_fail++; $display("FAIL cooldown_cleared got %b want 1", chrg); end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_power_refill();
        test_o2_both();
        test_threat_hold();
        test_stealth_temp();
        test_fatal_abort();
        test_fatal_recover();
        test_fatal_threat_stealth();
        test_reset_mid_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ship_supervisor.md
SHIP_SUPERVISOR -- requirements
Module: ship_supervisor

Interface
REQ-001 SHALL have parameter n, default 32, datapath width of all resource/status buses.
REQ-002 SHALL have parameter PWR_LOW, default 20, power level below which a recharge is requested.
REQ-003 SHALL have parameter O2_LOW, default 20, O2 level below which a resupply is requested.
REQ-004 SHALL have parameter REFILL, default 500, value driven on pwr/o2 with each refill pulse.
REQ-005 SHALL have parameter TEMP_WARN, default 90, temperature at or above which stealth is abandoned.
REQ-006 SHALL have parameter HOLD, default 8, cycles DEFEND persists after threat clears.
REQ-007 SHALL have parameter COOLDOWN, default 4, minimum idle cycles between refill pulses of one resource.
REQ-008 SHALL have parameter ABORT_CYC, default 16, consecutive fatal cycles in EMERG that trigger abort.
REQ-009 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-010 SHALL have port rst  input  1  synchronous active-high reset.
REQ-011 SHALL have port threat  input  1  external attack indication.
REQ-012 SHALL have port req_stealth  input  1  crew request for stealth mode, level-sensitive.
REQ-013 SHALL have port outpower  input  n  current power level from life support.
REQ-014 SHALL have port outo2  input  n  current O2 level from life support.
REQ-015 SHALL have port outtemp  input  n  current temperature from life support.
REQ-016 SHALL have port fatal  input  1  life-support fatal flag.
REQ-017 SHALL have port mode  output  4  mode command to life support.
REQ-018 SHALL have port chrg  output  1  one-cycle power refill strobe.
REQ-019 SHALL have port o2sup  output  1  one-cycle O2 refill strobe.
REQ-020 SHALL have port pwr  output  n  power refill value, REFILL when chrg=1 else 0.
REQ-021 SHALL have port o2  output  n  O2 refill value, REFILL when o2sup=1 else 0.
REQ-022 SHALL have port atk  output  1  registered copy of threat, forced 0 in ABORT.
REQ-023 SHALL have port abort  output  1  terminal abort flag.
REQ-024 SHALL have port state  output  3  FSM state: CRUISE=0, DEFEND=1, STEALTH=2, EMERG=3, ABORT=4.

Function
REQ-025 SHALL register all outputs; each is a function of inputs sampled at the same rising edge (1-cycle latency).
REQ-026 SHALL drive mode CRUISE=0001, DEFEND=0100, STEALTH=1000, EMERG=0010, ABORT=0000.
REQ-027 SHALL apply transition priority in every non-ABORT state: fatal > threat > stealth request > hold/stay.
REQ-028 CRUISE: fatal->EMERG; else threat->DEFEND; else req_stealth and outpower>PWR_LOW and outtemp<TEMP_WARN->STEALTH; else stay.
REQ-029 DEFEND: fatal->EMERG; threat reloads hold counter to HOLD; threat low decrements it; leaving to CRUISE on the cycle the counter reaches 0.
REQ-030 STEALTH: fatal->EMERG; threat->DEFEND (hold=HOLD); req_stealth low, outpower<=PWR_LOW or outtemp>=TEMP_WARN->CRUISE.
REQ-031 EMERG: fatal counter increments on each fatal cycle, clears and returns to CRUISE on first non-fatal cycle; reaching ABORT_CYC->ABORT.
REQ-032 ABORT: terminal; abort=1, chrg=o2sup=0, atk=0, mode=0000; left only by rst.
REQ-033 Power refill: chrg=1 for exactly one cycle when outpower<PWR_LOW (or any level in EMERG) and power cooldown=0 and state!=ABORT; cooldown then loads COOLDOWN, decrements to 0.
REQ-034 O2 refill SHALL follow REQ-033 independently using outo2, O2_LOW and its own cooldown; both strobes MAY fire in one cycle.
REQ-035 Counters SHALL saturate (no wrap); comparisons are unsigned n-bit.

Reset
REQ-036 On rst=1 at an edge: state=CRUISE, mode=0001, chrg=o2sup=0, pwr=o2=0, atk=0, abort=0, all counters 0; rst overrides every other input including in ABORT.
REQ-037 Reset mid-refill or mid-hold SHALL discard the pending operation with no residual strobe.

Verification
REQ-038 rst, then outpower=10, outo2=100 -> chrg=1, pwr=500 for one cycle, next chrg no earlier than 5 cycles later if outpower stays 10.
REQ-039 CRUISE, threat pulse of 1 cycle -> mode=0100 next cycle, returns to 0001 exactly HOLD=8 cycles after threat drop.
REQ-040 STEALTH with outtemp ramping 88,89,90 -> mode 1000 until outtemp=90 sampled, then 0001.
REQ-041 fatal held 16 cycles -> EMERG (0010) then ABORT, abort=1, refills stop; fatal dropped at cycle 10 -> CRUISE, no abort.
REQ-042 fatal and threat asserted together in STEALTH -> EMERG, not DEFEND; rst in ABORT -> CRUISE, abort=0 next cycle.
